// File: rtl/cache_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported cache: IDLE -> ISSUE -> CAPTURE.
// Optional hit/miss statistics counters are built when CACHE_ARB_STATS_EN is defined.
module cache_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req,
    input  logic [1:0]        we,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic [1:0]        gnt,
    output logic [1:0]        rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              rhit,
    output logic              c_read_en,
    output logic              c_write_en,
    output logic [ADDR_W-1:0] c_address,
    output logic [DATA_W-1:0] c_write_data,
    input  logic [DATA_W-1:0] c_read_data,
    input  logic              c_hit,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StIssue   = 2'd1;
    localparam logic [1:0] StCapture = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              prio_q, prio_d;   // 1: port 1 wins a tie
    logic              sel_q, sel_d;
    logic              we_q, we_d;
    logic [1:0]        gnt_q, gnt_d;
    logic [1:0]        rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rhit_q, rhit_d;
    logic              c_read_en_q, c_read_en_d;
    logic              c_write_en_q, c_write_en_d;
    logic [ADDR_W-1:0] c_address_q, c_address_d;
    logic [DATA_W-1:0] c_write_data_q, c_write_data_d;
    logic              pick;

    always_comb begin
        state_d        = state_q;
        prio_d         = prio_q;
        sel_d          = sel_q;
        we_d           = we_q;
        gnt_d          = 2'b00;
        rvalid_d       = 2'b00;
        rdata_d        = rdata_q;
        rhit_d         = rhit_q;
        c_read_en_d    = 1'b0;
        c_write_en_d   = 1'b0;
        c_address_d    = c_address_q;
        c_write_data_d = c_write_data_q;
        pick           = req[1] & (~req[0] | prio_q);
        case (state_q)
            StIdle: begin
                if (|req) begin
                    sel_d          = pick;
                    prio_d         = ~pick;
                    we_d           = we[pick];
                    gnt_d          = pick ? 2'b10 : 2'b01;
                    c_read_en_d    = ~we[pick];
                    c_write_en_d   = we[pick];
                    c_address_d    = pick ? addr1 : addr0;
                    c_write_data_d = pick ? wdata1 : wdata0;
                    state_d        = StIssue;
                end
            end
            StIssue: begin
                state_d = StCapture;
            end
            StCapture: begin
                rvalid_d = sel_q ? 2'b10 : 2'b01;
                rhit_d   = c_hit;
                rdata_d  = we_q ? '0 : c_read_data;
                state_d  = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            prio_q         <= 1'b0;
            sel_q          <= 1'b0;
            we_q           <= 1'b0;
            gnt_q          <= 2'b00;
            rvalid_q       <= 2'b00;
            rdata_q        <= '0;
            rhit_q         <= 1'b0;
            c_read_en_q    <= 1'b0;
            c_write_en_q   <= 1'b0;
            c_address_q    <= '0;
            c_write_data_q <= '0;
        end else begin
            state_q        <= state_d;
            prio_q         <= prio_d;
            sel_q          <= sel_d;
            we_q           <= we_d;
            gnt_q          <= gnt_d;
            rvalid_q       <= rvalid_d;
            rdata_q        <= rdata_d;
            rhit_q         <= rhit_d;
            c_read_en_q    <= c_read_en_d;
            c_write_en_q   <= c_write_en_d;
            c_address_q    <= c_address_d;
            c_write_data_q <= c_write_data_d;
        end
    end

    assign gnt          = gnt_q;
    assign rvalid       = rvalid_q;
    assign rdata        = rdata_q;
    assign rhit         = rhit_q;
    assign c_read_en    = c_read_en_q;
    assign c_write_en   = c_write_en_q;
    assign c_address    = c_address_q;
    assign c_write_data = c_write_data_q;

`ifdef CACHE_ARB_STATS_EN
    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

    // Counted from the registered completion pulse, so they trail rvalid by one cycle.
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (|rvalid_q) begin
            if (rhit_q) begin
                if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + CntOne;
            end else begin
                if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + CntOne;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter with a small behavioural cache that allocates on miss.
module tb_cache_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req;
    logic [1:0]  we;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic [1:0]  gnt, rvalid;
    logic [31:0] rdata;
    logic        rhit;
    logic        c_read_en, c_write_en;
    logic [31:0] c_address, c_write_data;
    logic [31:0] c_read_data = 32'h0;
    logic        c_hit = 1'b0;
    logic [15:0] hit_count, miss_count;

    int n_vec = 0;
    int n_err = 0;
    int exp_hits = 0;
    int exp_misses = 0;

    logic [31:0] mem [logic [31:0]];

    cache_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .we           (we),
        .addr0        (addr0),
        .addr1        (addr1),
        .wdata0       (wdata0),
        .wdata1       (wdata1),
        .gnt          (gnt),
        .rvalid       (rvalid),
        .rdata        (rdata),
        .rhit         (rhit),
        .c_read_en    (c_read_en),
        .c_write_en   (c_write_en),
        .c_address    (c_address),
        .c_write_data (c_write_data),
        .c_read_data  (c_read_data),
        .c_hit        (c_hit),
        .hit_count    (hit_count),
        .miss_count   (miss_count)
    );

    always #5 clk = ~clk;

    // Cache answers in the cycle after the access; read misses allocate a zero line.
    always @(posedge clk) begin
        if (c_read_en || c_write_en) begin
            c_hit = mem.exists(c_address);
            if (c_write_en) begin
                mem[c_address] = c_write_data;
                c_read_data = 32'hA5A5_A5A5;
            end else begin
                if (!c_hit) mem[c_address] = 32'h0;
                c_read_data = mem[c_address];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic count(input bit h);
        if (h) exp_hits++;
        else exp_misses++;
    endtask

    task automatic check_stats(input string tag);
`ifdef CACHE_ARB_STATS_EN
        check({tag, "_hits"}, 64'(hit_count), 64'(exp_hits));
        check({tag, "_misses"}, 64'(miss_count), 64'(exp_misses));
`else
        check({tag, "_hits"}, 64'(hit_count), 64'h0);
        check({tag, "_misses"}, 64'(miss_count), 64'h0);
`endif
    endtask

    // Single request from one port; leaves the bench in the rvalid cycle.
    task automatic do_op(input string tag, input int p, input bit w, input logic [31:0] a,
                         input logic [31:0] d, input bit exp_hit, input logic [31:0] exp_rd);
        req = (p == 1) ? 2'b10 : 2'b01;
        we  = w ? req : 2'b00;
        if (p == 1) begin addr1 = a; wdata1 = d; end
        else begin addr0 = a; wdata0 = d; end
        tick();
        check({tag, "_gnt"}, 64'(gnt), 64'(req));
        check({tag, "_ren"}, 64'(c_read_en), 64'(!w));
        check({tag, "_wen"}, 64'(c_write_en), 64'(w));
        check({tag, "_addr"}, 64'(c_address), 64'(a));
        if (w) check({tag, "_wdata"}, 64'(c_write_data), 64'(d));
        req = 2'b00;
        tick();
        check({tag, "_cap_gnt"}, 64'(gnt), 64'h0);
        check({tag, "_cap_en"}, 64'({c_read_en, c_write_en}), 64'h0);
        check({tag, "_cap_rvalid"}, 64'(rvalid), 64'h0);
        tick();
        check({tag, "_rvalid"}, 64'(rvalid), (p == 1) ? 64'h2 : 64'h1);
        check({tag, "_rhit"}, 64'(rhit), 64'(exp_hit));
        check({tag, "_rdata"}, 64'(rdata), 64'(exp_rd));
        count(exp_hit);
    endtask

    initial begin
        rst_n = 1'b0; req = 2'b00; we = 2'b00;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        tick(); tick(); tick();
        check("rst_gnt", 64'(gnt), 64'h0);
        check("rst_rvalid", 64'(rvalid), 64'h0);
        check("rst_rdata", 64'(rdata), 64'h0);
        check("rst_rhit", 64'(rhit), 64'h0);
        check("rst_en", 64'({c_read_en, c_write_en}), 64'h0);
        check("rst_addr", 64'(c_address), 64'h0);
        check("rst_wdata", 64'(c_write_data), 64'h0);
        check_stats("rst");
        rst_n = 1'b1;
        tick(); tick();
        check("idle_gnt", 64'(gnt), 64'h0);
        check("idle_en", 64'({c_read_en, c_write_en}), 64'h0);

        do_op("rd0_miss", 0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        do_op("rd0_hit", 0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
        tick();
        check_stats("stats_a");

        do_op("wr200", 0, 1'b1, 32'h200, 32'hDEAD_BEEF, 1'b0, 32'h0);
        do_op("rd200", 0, 1'b0, 32'h200, 32'h0, 1'b1, 32'hDEAD_BEEF);
        tick(); tick();
        check("hold_rdata", 64'(rdata), 64'hDEAD_BEEF);
        check("hold_rhit", 64'(rhit), 64'h1);
        check("hold_rvalid", 64'(rvalid), 64'h0);

        // Last grant was port 0, so a lone port 1 request goes straight through.
        do_op("p1_only", 1, 1'b0, 32'h300, 32'h0, 1'b0, 32'h0);

        req = 2'b11; we = 2'b00; addr0 = 32'h40; addr1 = 32'h80;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("rr%0d_gnt", k), 64'(gnt), (k % 2 == 0) ? 64'h1 : 64'h2);
            check($sformatf("rr%0d_addr", k), 64'(c_address), (k % 2 == 0) ? 64'h40 : 64'h80);
            tick();
            check($sformatf("rr%0d_gap", k), 64'(gnt), 64'h0);
            tick();
            check($sformatf("rr%0d_gap2", k), 64'(gnt), 64'h0);
            check($sformatf("rr%0d_rvalid", k), 64'(rvalid), (k % 2 == 0) ? 64'h1 : 64'h2);
            check($sformatf("rr%0d_rhit", k), 64'(rhit), 64'(k >= 2));
            count(k >= 2);
            if (k == 3) req = 2'b00;
        end
        tick();
        check("rr_done_gnt", 64'(gnt), 64'h0);
        check_stats("stats_b");

        // Reset lands while the op is in CAPTURE.
        req = 2'b10; addr1 = 32'h80;
        tick();
        check("mid_gnt", 64'(gnt), 64'h2);
        req = 2'b00;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid_rvalid", 64'(rvalid), 64'h0);
        check("mid_rdata", 64'(rdata), 64'h0);
        check("mid_rhit", 64'(rhit), 64'h0);
        check("mid_en", 64'({c_read_en, c_write_en}), 64'h0);
        check("mid_addr", 64'(c_address), 64'h0);
        exp_hits = 0; exp_misses = 0;
        check_stats("mid");
        tick();
        check("post_rvalid", 64'(rvalid), 64'h0);
        req = 2'b11; addr0 = 32'h40; addr1 = 32'h80;
        tick();
        check("post_gnt", 64'(gnt), 64'h1);
        req = 2'b00;
        tick(); tick();
        check("post_rvalid2", 64'(rvalid), 64'h1);
        check("post_rhit", 64'(rhit), 64'h1);
        count(1'b1);
        tick();
        check_stats("stats_c");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
